tl_tx_arbiter: RTL and testbench
================================

# tl_tx_arbiter

Transaction-layer TX scheduler that shares the single TL→DLL transmit stream between three TLP sources: Posted (P), Non-Posted (NP) and Completion (CPL). It tracks per-type link-partner flow-control credits from DLL credit updates. It grants a source only when that source's credit requirement is met, then locks the grant until the packet's last beat is accepted. It sits between the TL request/completion generators and the DLL interface.

## Interface

Parameters:
- `DATA_W`, 256: beat payload width in bits.
- `CRED_W`, 12: credit counter width; matches the `credits` field of a DLL credit update.
- `COST_W`, 8: per-TLP credit cost width.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_data_i[3]`, input, 3×DATA_W: source beat data; index 0 = P, 1 = NP, 2 = CPL.
- `req_sop_i[3]`, input, 3: first beat of a TLP.
- `req_eop_i[3]`, input, 3: last beat of a TLP.
- `req_valid_i[3]`, input, 3: source beat valid.
- `req_cost_i[3]`, input, 3×COST_W: credit cost of the TLP; sampled only while sop and valid are high.
- `req_ready_o[3]`, output, 3: beat accepted from this source.
- `tl_tx_data_o`, output, DATA_W: beat data to DLL.
- `tl_tx_sop_o`, output, 1: first-beat marker to DLL.
- `tl_tx_eop_o`, output, 1: last-beat marker to DLL.
- `tl_tx_valid_o`, output, 1: beat valid to DLL.
- `tl_tx_ready_i`, input, 1: DLL accepts beat.
- `fc_valid_i`, input, 1: credit update strobe.
- `fc_type_i`, input, 2: credit type; 0 = P, 1 = NP, 2 = CPL, 3 = ignored.
- `fc_credits_i`, input, CRED_W: credits to add to the selected type.
- `credit_o[3]`, output, 3×CRED_W: current credit counters, for debug and scoreboard.
- `busy_o`, output, 1: high while in XFER.

## Operation

- State machine with two states: IDLE and XFER.
- Eligibility:
  - Source i is eligible when `req_valid_i[i] && req_sop_i[i] && credit[i] >= req_cost_i[i]`.
  - Cost 0 is always eligible.
  - A valid beat without sop while in IDLE is a protocol error. It is not granted; the source stays stalled.
- IDLE behaviour:
  - Select among eligible sources by round-robin.
  - Search starts at `(last_grant + 1) mod 3`; `last_grant` resets to 2, so P has priority first.
  - On a grant: latch `sel`, set `last_grant = sel`, deduct `req_cost_i[sel]` from `credit[sel]`, and go to XFER.
  - If no source is eligible, stay in IDLE.
- XFER behaviour (pass-through from the selected source):
  - `tl_tx_* = req_*[sel]`.
  - `req_ready_o[sel] = tl_tx_ready_i`; all other `req_ready_o` are 0.
  - When a beat is accepted (`valid && ready`) with eop set, return to IDLE.
- Credits:
  - Each counter is unsigned CRED_W bits.
  - On `fc_valid_i`, add `fc_credits_i` to `credit[fc_type_i]`, saturating at 2^CRED_W−1.
  - If an update and a deduction hit the same counter in the same cycle, the result is `sat(credit + add) − cost`. Both are applied and neither is lost.
  - A deduction never underflows, because eligibility guarantees `credit >= cost`.
- Grant locking: the selected source is never changed mid-packet, regardless of credit updates or other requests.

## Timing

- Reset values:
  - State IDLE, `sel = 0`, `last_grant = 2`.
  - All `credit_o = 0`.
  - `tl_tx_valid_o = 0`; `tl_tx_sop_o`, `tl_tx_eop_o` and `tl_tx_data_o` = 0 (outputs are gated by state).
  - `req_ready_o = 0`, `busy_o = 0`.
- Grant latency: the eligibility decision is made in cycle N (IDLE). The first beat is presented in cycle N+1, with `busy_o = 1` from N+1.
- Packet gap: after the eop beat is accepted in cycle M, the state is IDLE in M+1. The next packet's first beat appears no earlier than M+2, giving one bubble cycle.
- Single-beat TLPs (sop and eop together) complete in one XFER cycle if `tl_tx_ready_i` is high.
- Backpressure: when `tl_tx_ready_i` is 0, the source holds its beat. Outputs follow the source combinationally; no beat is duplicated or dropped.
- Credit timing:
  - A credit update in cycle N is visible on `credit_o` and in eligibility from cycle N+1.
  - The deduction at a grant in cycle N is visible in N+1.
- Mid-operation reset: asserting `rst_n` low returns the block to its reset state immediately. The in-flight packet is abandoned and the sources must restart from sop.

## Test plan

- Credits: P=0. Request a P TLP with cost 4 and 2 beats → no grant. Send fc P+4 → grant two cycles after the update; 2 beats out; `credit_o[0] = 0`.
- Round-robin: all three sources hold sufficient credits and have single-beat TLPs pending continuously → grant order P, NP, CPL, P, NP, CPL, with one bubble between packets.
- Backpressure: 3-beat NP TLP with `tl_tx_ready_i` toggling 1,0,0,1,1 → exactly 3 beats out in order, eop on the 5th cycle, CPL is not granted mid-packet.
- Simultaneous update and deduction: CPL credit 10, fc CPL+5 in the same cycle as a CPL grant with cost 8 → `credit_o[2] = 7`.
- Saturation: P credit 4090, fc P+100 → `credit_o[0] = 4095`. An fc update with type 3 changes no counter.
- Reset mid-XFER: drop `rst_n` on beat 2 of 4 → `tl_tx_valid_o = 0` and credits = 0 immediately; after release, the block sits in IDLE awaiting a new sop.

Source files
------------

// File: rtl/tl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// TlTxArbiter (module tl_tx_arbiter)
//
// Transaction-layer TX scheduler. Three TLP sources (0 = Posted,
// 1 = Non-Posted, 2 = Completion) share the single TL->DLL beat stream.
// A source is granted only when its link-partner credit covers the TLP
// cost. The grant then stays locked until that packet's eop beat is
// accepted. Credits are replenished by DLL credit updates.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_data_i[3]          : per-source beat payload
//   req_sop_i[3]           : per-source first-beat marker
//   req_eop_i[3]           : per-source last-beat marker
//   req_valid_i[3]         : per-source beat valid
//   req_cost_i[3]          : per-source TLP credit cost (meaningful with sop)
//   req_ready_o[3]         : per-source beat accepted
//   tl_tx_data_o           : beat payload to DLL
//   tl_tx_sop_o            : first-beat marker to DLL
//   tl_tx_eop_o            : last-beat marker to DLL
//   tl_tx_valid_o          : beat valid to DLL
//   tl_tx_ready_i          : DLL accepts beat
//   fc_valid_i             : credit update strobe
//   fc_type_i              : credit type (0 P, 1 NP, 2 CPL, 3 ignored)
//   fc_credits_i           : credits to add to the selected type
//   credit_o[3]            : current credit counters
//   busy_o                 : high while a packet is being forwarded
// ---------------------------------------------------------------------------
module tl_tx_arbiter #(
  parameter int DATA_W = 256,
  parameter int CRED_W = 12,
  parameter int COST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] req_data_i  [3],
  input  logic              req_sop_i   [3],
  input  logic              req_eop_i   [3],
  input  logic              req_valid_i [3],
  input  logic [COST_W-1:0] req_cost_i  [3],
  output logic              req_ready_o [3],
  output logic [DATA_W-1:0] tl_tx_data_o,
  output logic              tl_tx_sop_o,
  output logic              tl_tx_eop_o,
  output logic              tl_tx_valid_o,
  input  logic              tl_tx_ready_i,
  input  logic              fc_valid_i,
  input  logic [1:0]        fc_type_i,
  input  logic [CRED_W-1:0] fc_credits_i,
  output logic [CRED_W-1:0] credit_o    [3],
  output logic              busy_o
);

  // Credit/cost comparison is done at the wider of the two widths so that
  // neither operand is truncated.
  localparam int CMP_W = (CRED_W > COST_W) ? CRED_W : COST_W;

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [CRED_W-1:0] credit_q [3];
  logic [CRED_W-1:0] credit_d [3];

  logic              eligible [3];
  logic              grant;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic              deduct;
  logic [CRED_W:0]   cred_sum [3];
  logic [CRED_W-1:0] cred_sat [3];
  logic [CRED_W-1:0] cred_sub [3];

  // Modulo-3 increment for the round-robin pointer.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // A source may start only on a sop beat whose cost is covered by the
  // current credit; a mid-packet beat seen in IDLE is never granted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      eligible[i] = req_valid_i[i] && req_sop_i[i] &&
                    (CMP_W'(credit_q[i]) >= CMP_W'(req_cost_i[i]));
    end
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    grant     = 1'b0;
    grant_idx = 2'd0;
    cand      = wrap_inc(last_grant_q);
    for (int k = 0; k < 3; k++) begin
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Next-state logic: grant in IDLE, release on an accepted eop beat.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    deduct       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = XFER;
          sel_d        = grant_idx;
          last_grant_d = grant_idx;
          deduct       = 1'b1;
        end
      end
      XFER: begin
        if (req_valid_i[sel_q] && tl_tx_ready_i && req_eop_i[sel_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit update: saturating add first, then the grant deduction, so a
  // same-cycle update and deduction on one counter are both applied.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cred_sum[i] = {1'b0, credit_q[i]};
      if (fc_valid_i && (fc_type_i == 2'(i))) begin
        cred_sum[i] = {1'b0, credit_q[i]} + {1'b0, fc_credits_i};
      end
      cred_sat[i] = cred_sum[i][CRED_W] ? {CRED_W{1'b1}} : cred_sum[i][CRED_W-1:0];
      cred_sub[i] = '0;
      if (deduct && (grant_idx == 2'(i))) begin
        cred_sub[i] = CRED_W'(req_cost_i[i]);
      end
      credit_d[i] = cred_sat[i] - cred_sub[i];
    end
  end

  // Pass-through of the selected source; everything is zero outside XFER.
  always_comb begin
    tl_tx_data_o  = '0;
    tl_tx_sop_o   = 1'b0;
    tl_tx_eop_o   = 1'b0;
    tl_tx_valid_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_ready_o[i] = 1'b0;
    end
    if (state_q == XFER) begin
      tl_tx_data_o       = req_data_i[sel_q];
      tl_tx_sop_o        = req_sop_i[sel_q];
      tl_tx_eop_o        = req_eop_i[sel_q];
      tl_tx_valid_o      = req_valid_i[sel_q];
      req_ready_o[sel_q] = tl_tx_ready_i;
    end
  end

  assign busy_o   = (state_q == XFER);
  assign credit_o = credit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      last_grant_q <= 2'd2;
      for (int i = 0; i < 3; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 3; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for tl_tx_arbiter: directed vectors with hand-computed
// expectations covering reset, credit gating, round-robin order,
// backpressure, simultaneous credit update and deduction, saturation,
// ignored credit type and reset in the middle of a packet.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_tl_tx_arbiter;

  logic         clk;
  logic         rstN;
  logic [255:0] reqData  [3];
  logic         reqSop   [3];
  logic         reqEop   [3];
  logic         reqValid [3];
  logic [7:0]   reqCost  [3];
  logic         reqReady [3];
  logic [255:0] txData;
  logic         txSop;
  logic         txEop;
  logic         txValid;
  logic         txReady;
  logic         fcValid;
  logic [1:0]   fcType;
  logic [11:0]  fcCredits;
  logic [11:0]  creditOut [3];
  logic         busy;

  int checkCount;
  int errorCount;

  tl_tx_arbiter dut (
    .clk           (clk),
    .rst_n         (rstN),
    .req_data_i    (reqData),
    .req_sop_i     (reqSop),
    .req_eop_i     (reqEop),
    .req_valid_i   (reqValid),
    .req_cost_i    (reqCost),
    .req_ready_o   (reqReady),
    .tl_tx_data_o  (txData),
    .tl_tx_sop_o   (txSop),
    .tl_tx_eop_o   (txEop),
    .tl_tx_valid_o (txValid),
    .tl_tx_ready_i (txReady),
    .fc_valid_i    (fcValid),
    .fc_type_i     (fcType),
    .fc_credits_i  (fcCredits),
    .credit_o      (creditOut),
    .busy_o        (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one source's beat.
  task automatic applyStimulus(input int src, input bit valid, input bit sop,
                               input bit eop, input int cost, input logic [31:0] data);
    reqValid[src] = valid;
    reqSop[src]   = sop;
    reqEop[src]   = eop;
    reqCost[src]  = 8'(cost);
    reqData[src]  = {224'd0, data};
  endtask

  // Advance to the next falling edge where inputs are changed.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic sendCredit(input int kind, input int amount);
    fcValid   = 1'b1;
    fcType    = 2'(kind);
    fcCredits = 12'(amount);
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 3; i++) applyStimulus(i, 0, 0, 0, 0, 32'h0);
    fcValid   = 1'b0;
    fcType    = 2'd0;
    fcCredits = 12'd0;
    txReady   = 1'b1;
  endtask

  task automatic doReset();
    nextCycle();
    rstN = 1'b0;
    clearInputs();
    nextCycle();
    nextCycle();
    rstN = 1'b1;
  endtask

  // Expected grant per step in the round-robin run (-1 = bubble/idle).
  int rrExpect [12] = '{-1, 0, -1, 1, -1, 2, -1, 0, -1, 1, -1, 2};

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN = 1'b0;
    clearInputs();

    // ---------------- reset state, with a source already requesting ----
    applyStimulus(0, 1, 1, 1, 0, 32'hDEAD);
    #12;
    checkOutput("rst_valid", 32'(txValid), 32'd0);
    checkOutput("rst_sop", 32'(txSop), 32'd0);
    checkOutput("rst_eop", 32'(txEop), 32'd0);
    checkOutput("rst_data", txData[31:0], 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready0", 32'(reqReady[0]), 32'd0);
    checkOutput("rst_credit0", 32'(creditOut[0]), 32'd0);
    checkOutput("rst_credit2", 32'(creditOut[2]), 32'd0);
    doReset();

    // ---------------- credit gating on P ----------------
    applyStimulus(0, 1, 1, 0, 4, 32'h11);
    #1;
    checkOutput("cg_nocredit_busy", 32'(busy), 32'd0);
    nextCycle(); #1;
    checkOutput("cg_stall_busy", 32'(busy), 32'd0);
    checkOutput("cg_stall_ready", 32'(reqReady[0]), 32'd0);
    nextCycle();
    sendCredit(0, 4);
    #1;
    checkOutput("cg_upd_busy", 32'(busy), 32'd0);
    checkOutput("cg_upd_credit", 32'(creditOut[0]), 32'd0);
    nextCycle();
    fcValid = 1'b0;
    #1;
    checkOutput("cg_credit4", 32'(creditOut[0]), 32'd4);
    checkOutput("cg_decide_busy", 32'(busy), 32'd0);
    nextCycle(); #1;
    checkOutput("cg_b1_busy", 32'(busy), 32'd1);
    checkOutput("cg_b1_sop", 32'(txSop), 32'd1);
    checkOutput("cg_b1_data", txData[31:0], 32'h11);
    checkOutput("cg_b1_ready", 32'(reqReady[0]), 32'd1);
    checkOutput("cg_credit0", 32'(creditOut[0]), 32'd0);
    nextCycle();
    applyStimulus(0, 1, 0, 1, 4, 32'h12);
    #1;
    checkOutput("cg_b2_sop", 32'(txSop), 32'd0);
    checkOutput("cg_b2_eop", 32'(txEop), 32'd1);
    checkOutput("cg_b2_data", txData[31:0], 32'h12);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("cg_done_busy", 32'(busy), 32'd0);
    checkOutput("cg_done_credit", 32'(creditOut[0]), 32'd0);

    // ---------------- round-robin from reset ----------------
    doReset();
    sendCredit(0, 10);
    nextCycle(); sendCredit(1, 10);
    nextCycle(); sendCredit(2, 10);
    nextCycle(); fcValid = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1, 1, 1, 1, 32'hA0 + 32'(i));
    for (int s = 0; s < 12; s++) begin
      if (s != 0) nextCycle();
      #1;
      checkOutput($sformatf("rr%0d_busy", s), 32'(busy), (rrExpect[s] >= 0) ? 32'd1 : 32'd0);
      if (rrExpect[s] >= 0) begin
        checkOutput($sformatf("rr%0d_data", s), txData[31:0], 32'hA0 + 32'(rrExpect[s]));
        checkOutput($sformatf("rr%0d_ready", s),
                    {29'd0, reqReady[2], reqReady[1], reqReady[0]},
                    32'd1 << rrExpect[s]);
      end
    end
    nextCycle();
    for (int i = 0; i < 3; i++) applyStimulus(i, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("rr_credit0", 32'(creditOut[0]), 32'd8);
    checkOutput("rr_credit1", 32'(creditOut[1]), 32'd8);
    checkOutput("rr_credit2", 32'(creditOut[2]), 32'd8);

    // ---------------- backpressure on a 3-beat NP TLP ----------------
    nextCycle();
    applyStimulus(1, 1, 1, 0, 2, 32'hB1);
    applyStimulus(2, 1, 1, 1, 1, 32'hC1);
    txReady = 1'b1;
    #1;
    checkOutput("bp_idle_busy", 32'(busy), 32'd0);
    nextCycle(); #1;
    checkOutput("bp_b1_data", txData[31:0], 32'hB1);
    checkOutput("bp_b1_ready1", 32'(reqReady[1]), 32'd1);
    checkOutput("bp_b1_ready2", 32'(reqReady[2]), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 0, 0, 2, 32'hB2);
    txReady = 1'b0;
    #1;
    checkOutput("bp_hold1_data", txData[31:0], 32'hB2);
    checkOutput("bp_hold1_ready", 32'(reqReady[1]), 32'd0);
    checkOutput("bp_hold1_valid", 32'(txValid), 32'd1);
    nextCycle(); #1;
    checkOutput("bp_hold2_data", txData[31:0], 32'hB2);
    checkOutput("bp_hold2_busy", 32'(busy), 32'd1);
    nextCycle();
    txReady = 1'b1;
    #1;
    checkOutput("bp_b2_ready", 32'(reqReady[1]), 32'd1);
    checkOutput("bp_b2_eop", 32'(txEop), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 0, 1, 2, 32'hB3);
    #1;
    checkOutput("bp_b3_eop", 32'(txEop), 32'd1);
    checkOutput("bp_b3_data", txData[31:0], 32'hB3);
    checkOutput("bp_b3_cpl_ready", 32'(reqReady[2]), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("bp_gap_busy", 32'(busy), 32'd0);
    nextCycle(); #1;
    checkOutput("bp_cpl_data", txData[31:0], 32'hC1);
    checkOutput("bp_cpl_ready", 32'(reqReady[2]), 32'd1);
    checkOutput("bp_credit1", 32'(creditOut[1]), 32'd6);
    nextCycle();
    applyStimulus(2, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("bp_end_busy", 32'(busy), 32'd0);
    checkOutput("bp_credit2", 32'(creditOut[2]), 32'd7);

    // ---------------- simultaneous update and deduction on CPL ----------
    nextCycle(); sendCredit(2, 3);
    nextCycle(); fcValid = 1'b0;
    #1;
    checkOutput("sim_credit10", 32'(creditOut[2]), 32'd10);
    nextCycle();
    applyStimulus(2, 1, 1, 1, 8, 32'hD1);
    sendCredit(2, 5);
    #1;
    checkOutput("sim_decide_busy", 32'(busy), 32'd0);
    nextCycle();
    fcValid = 1'b0;
    #1;
    checkOutput("sim_credit7", 32'(creditOut[2]), 32'd7);
    checkOutput("sim_data", txData[31:0], 32'hD1);
    nextCycle();
    applyStimulus(2, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("sim_end_credit", 32'(creditOut[2]), 32'd7);

    // ---------------- saturation and ignored type ----------------
    nextCycle(); sendCredit(0, 4082);
    nextCycle(); fcValid = 1'b0;
    #1;
    checkOutput("sat_credit4090", 32'(creditOut[0]), 32'd4090);
    nextCycle(); sendCredit(0, 100);
    nextCycle(); fcValid = 1'b0;
    #1;
    checkOutput("sat_credit4095", 32'(creditOut[0]), 32'd4095);
    nextCycle(); sendCredit(3, 50);
    nextCycle(); fcValid = 1'b0;
    #1;
    checkOutput("t3_credit0", 32'(creditOut[0]), 32'd4095);
    checkOutput("t3_credit1", 32'(creditOut[1]), 32'd6);
    checkOutput("t3_credit2", 32'(creditOut[2]), 32'd7);

    // ---------------- reset in the middle of a 4-beat P TLP ----------
    nextCycle();
    applyStimulus(0, 1, 1, 0, 1, 32'hE1);
    nextCycle(); #1;
    checkOutput("mr_b1_data", txData[31:0], 32'hE1);
    nextCycle();
    applyStimulus(0, 1, 0, 0, 0, 32'hE2);
    #1;
    checkOutput("mr_b2_data", txData[31:0], 32'hE2);
    rstN = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(txValid), 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    checkOutput("mr_ready0", 32'(reqReady[0]), 32'd0);
    checkOutput("mr_credit0", 32'(creditOut[0]), 32'd0);
    checkOutput("mr_credit1", 32'(creditOut[1]), 32'd0);
    nextCycle();
    rstN = 1'b1;
    for (int s = 0; s < 3; s++) begin
      nextCycle(); #1;
      checkOutput($sformatf("mr_nosop%0d_busy", s), 32'(busy), 32'd0);
      checkOutput($sformatf("mr_nosop%0d_ready", s), 32'(reqReady[0]), 32'd0);
    end
    nextCycle();
    applyStimulus(0, 1, 1, 1, 0, 32'hF1);
    #1;
    checkOutput("mr_sop_idle", 32'(busy), 32'd0);
    nextCycle(); #1;
    checkOutput("mr_restart_busy", 32'(busy), 32'd1);
    checkOutput("mr_restart_sop", 32'(txSop), 32'd1);
    checkOutput("mr_restart_data", txData[31:0], 32'hF1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
